// File: rtl/mux2_arbiter_if.sv
// Two-requester shared channel bundle: request/data in, grants, select and the muxed beat out.
// The slave modport is the arbiter's view; the master modport is the producers' and sink's view.
interface mux2_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic             out_ready;
    logic             gnt0;
    logic             gnt1;
    logic             sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             preempt;

    modport master (
        output req0, req1, data0, data1, out_ready,
        input  gnt0, gnt1, sel, out_valid, out_data, preempt
    );

    modport slave (
        input  req0, req1, data0, data1, out_ready,
        output gnt0, gnt1, sel, out_valid, out_data, preempt
    );
endinterface

// File: rtl/mux2_arbiter.sv
// Round-robin 2:1 channel arbiter with registered grants, 1-cycle grant latency and a per-grant beat cap.
// out_ready low stalls the current grant in place; state and the hold count freeze until it returns.
module mux2_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic            clk,
    input  logic            rst,
    mux2_arbiter_if.slave   bus
);
    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state;
    logic             r_last;
    logic             w_last;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt;
    logic             r_preempt;
    logic             w_preempt;
    logic             w_valid;
    logic             w_beat;
    logic             w_cnt_max;

    assign w_valid   = ((r_state == GRANT0) && bus.req0) || ((r_state == GRANT1) && bus.req1);
    assign w_beat    = w_valid && bus.out_ready;
    assign w_cnt_max = (r_cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_last    <= 1'b1;
            r_cnt     <= '0;
            r_preempt <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_last    <= w_last;
            r_cnt     <= w_cnt;
            r_preempt <= w_preempt;
        end
    end

    // A release hands off without an idle bubble; the cap only bites when the other side is waiting.
    always_comb begin
        w_state   = r_state;
        w_last    = r_last;
        w_cnt     = r_cnt;
        w_preempt = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt = '0;
                if (bus.req0 && (!bus.req1 || r_last)) begin
                    w_state = GRANT0;
                    w_last  = 1'b0;
                end else if (bus.req1) begin
                    w_state = GRANT1;
                    w_last  = 1'b1;
                end
            end
            GRANT0: begin
                if (!bus.req0) begin
                    w_cnt = '0;
                    if (bus.req1) begin
                        w_state = GRANT1;
                        w_last  = 1'b1;
                    end else begin
                        w_state = IDLE;
                    end
                end else if (w_beat) begin
                    if (w_cnt_max && bus.req1) begin
                        w_state   = GRANT1;
                        w_last    = 1'b1;
                        w_cnt     = '0;
                        w_preempt = 1'b1;
                    end else if (!w_cnt_max) begin
                        w_cnt = r_cnt + CNT_W'(1);
                    end
                end
            end
            GRANT1: begin
                if (!bus.req1) begin
                    w_cnt = '0;
                    if (bus.req0) begin
                        w_state = GRANT0;
                        w_last  = 1'b0;
                    end else begin
                        w_state = IDLE;
                    end
                end else if (w_beat) begin
                    if (w_cnt_max && bus.req0) begin
                        w_state   = GRANT0;
                        w_last    = 1'b0;
                        w_cnt     = '0;
                        w_preempt = 1'b1;
                    end else if (!w_cnt_max) begin
                        w_cnt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state = IDLE;
                w_cnt   = '0;
            end
        endcase
    end

    assign bus.gnt0      = (r_state == GRANT0);
    assign bus.gnt1      = (r_state == GRANT1);
    assign bus.sel       = (r_state == GRANT1);
    assign bus.out_valid = w_valid;
    assign bus.out_data  = (r_state == GRANT1) ? bus.data1 : bus.data0;
    assign bus.preempt   = r_preempt;
endmodule
